// File: rtl/fixed_convert_twos_comp_if.sv
// Fixed-point to float converter bus: pipeline enable, fixed-point operand, float result.
// Ports: clk_en (advance enable), dataa (Q-format two's complement), result (IEEE-754 single).
// Latency 3 enabled edges; no handshake, so clk_en is the only flow control.
interface fixed_convert_twos_comp_if #(
  parameter int DATA_WIDTH       = 22,
  parameter int FLOAT_DATA_WIDTH = 32
);
  logic                        clk_en;
  logic [DATA_WIDTH-1:0]       dataa;
  logic [FLOAT_DATA_WIDTH-1:0] result;

  // Producer/consumer side: drives operand and enable, observes the result.
  modport master (
    output clk_en,
    output dataa,
    input  result
  );

  // Converter side.
  modport slave (
    input  clk_en,
    input  dataa,
    output result
  );
endinterface

// File: rtl/fixed_convert_twos_comp.sv
// Exact two's-complement fixed-point (Q INTEGER_WIDTH.FRACTIONAL_WIDTH) to IEEE-754 single converter.
// Latency: 3 enabled clock edges (abs value -> normalise -> pack), one sample per enabled edge.
// Backpressure: none; clk_en low freezes every stage, aclr (sync, active-high) overrides clk_en.
// Ports: clock, aclr; bus.slave carries clk_en, dataa (input) and result (registered output).
module fixed_convert_twos_comp #(
  parameter int INTEGER_WIDTH    = 2,
  parameter int FRACTIONAL_WIDTH = 20,
  parameter int FLOAT_DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      aclr,
  fixed_convert_twos_comp_if.slave  bus
);

  localparam int DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  localparam int LW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // A 24-bit significand is the most a single can hold exactly; wider inputs would need rounding.
  if (DATA_WIDTH > 24 || DATA_WIDTH < 2) begin : g_bad_width
    $error("fixed_convert_twos_comp: DATA_WIDTH must be in 2..24");
  end
  if (FLOAT_DATA_WIDTH != 32) begin : g_bad_float
    $error("fixed_convert_twos_comp: only single precision is supported");
  end

  // ---------------- Stage 1: sign and magnitude ----------------
  logic                  sign1_d, sign1_q;
  logic [DATA_WIDTH-1:0] mag1_d,  mag1_q;

  // Magnitude is kept unsigned in DATA_WIDTH bits, so the most-negative input
  // negates to exactly 2^(DATA_WIDTH-1) without overflowing.
  always_comb begin
    sign1_d = bus.dataa[DATA_WIDTH-1];
    mag1_d  = sign1_d ? (~bus.dataa + DATA_WIDTH'(1)) : bus.dataa;
  end

  // ---------------- Stage 2: leading-one detect and normalise ----------------
  logic                  sign2_d, sign2_q;
  logic                  zero2_d, zero2_q;
  logic [7:0]            exp2_d,  exp2_q;
  logic [22:0]           mant2_d, mant2_q;
  logic [LW-1:0]         lead;
  logic [DATA_WIDTH-1:0] norm;

  always_comb begin
    // Highest set bit wins because later iterations overwrite earlier ones.
    lead = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (mag1_q[i]) lead = LW'(i);
    end
    norm    = mag1_q << (LW'(DATA_WIDTH - 1) - lead);
    zero2_d = (mag1_q == '0);
    // Zero never carries the sign, so -0 cannot be produced downstream.
    sign2_d = sign1_q & ~zero2_d;
    exp2_d  = 8'(127 + int'(lead) - FRACTIONAL_WIDTH);
    // Drop the implicit leading one and left-align the rest into the 23-bit field.
    mant2_d = '0;
    mant2_d[22 -: DATA_WIDTH-1] = norm[DATA_WIDTH-2:0];
  end

  // ---------------- Stage 3: pack ----------------
  logic [FLOAT_DATA_WIDTH-1:0] result_d, result_q;

  always_comb begin
    result_d = zero2_q ? '0 : {sign2_q, exp2_q, mant2_q};
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      sign1_q  <= 1'b0;
      mag1_q   <= '0;
      sign2_q  <= 1'b0;
      zero2_q  <= 1'b0;
      exp2_q   <= '0;
      mant2_q  <= '0;
      result_q <= '0;
    end else if (bus.clk_en) begin
      sign1_q  <= sign1_d;
      mag1_q   <= mag1_d;
      sign2_q  <= sign2_d;
      zero2_q  <= zero2_d;
      exp2_q   <= exp2_d;
      mant2_q  <= mant2_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_fixed_convert_twos_comp.sv
// Directed and swept checks of fixed_convert_twos_comp (Q2.20 -> IEEE-754 single).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand constants, or a real-arithmetic reference for the sweep.
module tb_fixed_convert_twos_comp;

  logic clock = 1'b0;
  logic aclr  = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  fixed_convert_twos_comp_if #(.DATA_WIDTH(22), .FLOAT_DATA_WIDTH(32)) bus ();

  fixed_convert_twos_comp #(
    .INTEGER_WIDTH(2), .FRACTIONAL_WIDTH(20), .FLOAT_DATA_WIDTH(32)
  ) dut (
    .clock(clock),
    .aclr (aclr),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (bus.result === exp) else begin
      n_err++;
      $error("FAIL %s: result=%h required=%h", tag, bus.result, exp);
    end
  endtask

  // Reference: exact conversion via double precision, then repacked as single.
  function automatic logic [31:0] ref_conv(input logic [21:0] v);
    real         r;
    logic [63:0] d;
    if (v == 22'd0) return 32'h0;
    r = real'($signed(v)) / 1048576.0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  logic [21:0] vin  [8] = '{22'h100000, 22'h300000, 22'h080000, 22'h000001,
                            22'h3FFFFF, 22'h1FFFFF, 22'h200000, 22'h000000};
  logic [31:0] vexp [8] = '{32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h35800000,
                            32'hB5800000, 32'h3FFFFFF8, 32'hC0000000, 32'h00000000};

  initial begin
    logic [31:0] s1, s2, s3;
    logic [21:0] v;

    // Reset held with clk_en low.
    bus.clk_en = 1'b0;
    bus.dataa  = 22'h0;
    tick();
    tick();
    chk("reset", 32'h0);

    // Known values, one at a time; result must be 0 before the 3rd edge after reset.
    aclr       = 1'b0;
    bus.clk_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.dataa = vin[k];
      tick();
      bus.dataa = 22'h0;
      if (k == 0) chk("post_reset_e1", 32'h0);
      tick();
      if (k == 0) chk("post_reset_e2", 32'h0);
      tick();
      chk($sformatf("known_%06h", vin[k]), vexp[k]);
    end

    // Back-to-back stream.
    bus.dataa = 22'h100000; tick();
    bus.dataa = 22'h300000; tick();
    bus.dataa = 22'h080000; tick();
    chk("stream_0", 32'h3F800000);
    bus.dataa = 22'h0; tick();
    chk("stream_1", 32'hBF800000);
    tick();
    chk("stream_2", 32'h3F000000);

    // Stall with the pipeline full; dataa toggles while frozen.
    bus.dataa = 22'h080000; tick();
    bus.dataa = 22'h300000; tick();
    bus.dataa = 22'h100000; tick();
    chk("stall_pre", 32'h3F000000);
    bus.clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.dataa = 22'($urandom);
      tick();
      chk("stall_hold", 32'h3F000000);
    end
    bus.clk_en = 1'b1;
    bus.dataa  = 22'h0;
    tick();
    chk("stall_resume_1", 32'hBF800000);
    tick();
    chk("stall_resume_2", 32'h3F800000);
    tick();
    chk("stall_resume_3", 32'h0);

    // Reset mid-pipeline: the in-flight value must vanish.
    bus.dataa = 22'h300000; tick();
    bus.dataa = 22'h0;
    aclr = 1'b1; tick();
    chk("midrst_clear", 32'h0);
    aclr = 1'b0;
    bus.dataa = 22'h080000; tick();
    chk("midrst_e1", 32'h0);
    bus.dataa = 22'h0; tick();
    chk("midrst_e2", 32'h0);
    tick();
    chk("midrst_e3", 32'h3F000000);

    // Reset while clk_en is low clears result and internal stages.
    bus.dataa = 22'h100000; tick(); tick(); tick();
    chk("rst_noen_pre", 32'h3F800000);
    bus.clk_en = 1'b0;
    aclr = 1'b1; tick();
    chk("rst_noen_clear", 32'h0);
    aclr = 1'b0; tick();
    chk("rst_noen_hold", 32'h0);
    bus.clk_en = 1'b1;
    bus.dataa  = 22'h0;
    tick();
    chk("rst_noen_flush1", 32'h0);
    tick();
    chk("rst_noen_flush2", 32'h0);

    // Streaming sweep: all low codes, then a spread over the full range.
    s1 = 32'h0; s2 = 32'h0; s3 = 32'h0;
    for (int i = 0; i < 1024 + 65536 + 2; i++) begin
      if (i < 1024)              v = 22'(i);
      else if (i < 1024 + 65536) v = 22'(((i - 1024) << 6) | (((i - 1024) * 37) & 63));
      else                       v = 22'h0;
      bus.dataa = v;
      tick();
      s3 = s2;
      s2 = s1;
      s1 = ref_conv(v);
      chk("sweep", s3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
